wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-cycle wide adder/subtractor. Operands of N*WORDS bits are added one
//  N-bit chunk per cycle through a single kogge_stone prefix-carry instance.
//  The chunk carry-out is registered and feeds the next chunk's carry-in.
//  Sits between an operand producer and a result consumer, each using a valid/ready handshake.
//  Trades latency for area versus a full-width prefix tree.
// PARAMETERS
//  N      16  chunk width; width of the kogge_stone instance (N >= 2)
//  WORDS  4   number of chunks; total operand width W = N*WORDS (WORDS >= 1)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   operand bundle valid
//  in_ready   out  1   sequencer can accept operands
//  a          in   W   operand A
//  b          in   W   operand B
//  cin        in   1   carry-in for chunk 0
//  sub        in   1   1: B is bit-inverted before the add
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  sum        out  W   result
//  cout       out  1   carry out of bit W-1
//  ovf        out  1   signed overflow: carry into bit W-1 XOR carry out of bit W-1
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset, asynchronous:
//    state=IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0.
//    in_ready=1 and busy=0 from the first edge after reset release.
//  - Reset mid-operation aborts the operation. No result is produced.
//  - Arithmetic:
//    sub=0 computes a+b+cin. sub=1 computes a+~b+cin.
//    For two's-complement a-b, the caller drives sub=1 with cin=1.
//  - kogge_stone hookup for chunk k, with bits i=1..N:
//    g[0] = carry register.
//    g[i] = A[kN+i-1] & B'[kN+i-1].
//    p[i] = A[kN+i-1] ^ B'[kN+i-1].
//    sum[kN+i-1] = p[i] ^ c[i-1].
//    Chunk carry-out = c[N]. Carry into the chunk MSB = c[N-1].
//  - FSM states IDLE, RUN, DONE:
//    IDLE: in_ready=1.
//      On in_valid&in_ready: latch a, B'=(sub ? ~b : b) and carry=cin.
//      Then set idx=0 and go to RUN.
//    RUN: in_ready=0.
//      Each cycle: compute chunk idx, write sum chunk idx, set carry=c[N], idx++.
//      When idx==WORDS-1, additionally set cout=c[N] and ovf=c[N-1]^c[N].
//      The FSM then moves to DONE.
//    DONE: out_valid=1, in_ready=0.
//      sum, cout and ovf are held stable while out_ready=0.
//      On out_ready the FSM returns to IDLE and out_valid falls next cycle.
//  - Latency and throughput:
//    Accept edge T gives out_valid high after edge T+WORDS.
//    No overlap: one operation per WORDS+2 cycles at best (accept, WORDS RUN, handshake).
//  - in_valid during RUN/DONE is ignored; the producer must hold it.
//  - sum keeps its last value after the handshake until the next operation
//    overwrites it chunk by chunk.
//  - idx width is max(1,$clog2(WORDS)).
//    WORDS=1 gives a single RUN cycle with no wrap logic.
//  - No combinational path from in_* to out_*.
//    in_ready and busy are decoded from state only.
// STRUCTURE
//  - Package wide_add_pkg holds:
//    typedef enum logic [1:0] {IDLE, RUN, DONE} wadd_state_t;
//    a localparam function for the counter width.
//  - One sub-module: kogge_stone #(.N(N)), used as the combinational carry network.
//    All sequencing, operand muxing and chunk slicing live in this module.
//  - Operand A/B' shift registers (shift right by N per RUN cycle) are preferred
//    to indexed part-selects.
// TESTING (N=16, WORDS=4 unless noted)
//  1. a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0
//     -> sum=0, cout=1, ovf=0; out_valid exactly 4 cycles after accept.
//  2. a=5, b=7, sub=1, cin=1
//     -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
//  3. a=64'h7FFF_FFFF_FFFF_FFFF, b=1
//     -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0.
//  4. Hold out_ready=0 for 10 cycles while in_valid=1 with new operands
//     -> sum/cout/ovf stable, in_ready=0, second op accepted only after the handshake.
//  5. Assert rst_n=0 during RUN at idx=2
//     -> out_valid=0 immediately, in_ready=1 after release; next op a=1,b=1 gives sum=2.
//  6. WORDS=1, a=16'hFFFF, b=1
//     -> sum=0, cout=1, out_valid 1 cycle after accept; back-to-back ops every 3 cycles.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the chunked wide adder/subtractor.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wadd_state_t;

  // Chunk index width; a single-chunk build still needs a 1-bit counter.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/kogge_stone.sv
// Kogge-Stone prefix carry network: c[i] is the carry out of bit i, with g[0] acting as carry-in.
module kogge_stone #(
  parameter int N = 16
) (
  input  logic [N:0] g,
  input  logic [N:1] p,
  output logic [N:0] c
);

  localparam int LV = $clog2(N + 1);

  logic [N:0] gv, pv, gn, pn;

  // Each level doubles the span of every (generate, propagate) group.
  always_comb begin
    gv = g;
    pv = {p, 1'b0};
    gn = '0;
    pn = '0;
    for (int l = 0; l < LV; l++) begin
      gn = gv;
      pn = pv;
      for (int i = 0; i <= N; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = gv[i] | (pv[i] & gv[i - (1 << l)]);
          pn[i] = pv[i] & pv[i - (1 << l)];
        end
      end
      gv = gn;
      pv = pn;
    end
    c = gv;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide add/subtract: one N-bit chunk per RUN cycle through a shared
// prefix-carry network, with the chunk carry registered between cycles.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int N     = 16,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy,
  output wadd_state_t          dbg_state
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);

  wadd_state_t   state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_sr, b_sr;
  logic [N:0]    kg, kc;
  logic [N:1]    kp;
  logic [N-1:0]  chunk_sum;
  logic          last;

  // Chunk 0 of the shift registers is always the chunk being added.
  assign kp        = a_sr[N-1:0] ^ b_sr[N-1:0];
  assign kg        = {a_sr[N-1:0] & b_sr[N-1:0], carry};
  assign chunk_sum = kp ^ kc[N-1:0];
  assign last      = (idx == IW'(WORDS - 1));

  kogge_stone #(.N(N)) u_ks (
    .g (kg),
    .p (kp),
    .c (kc)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and in_ready/busy decode state only.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx == IW'(k)) sum[k*N +: N] <= chunk_sum;
          end
          carry <= kc[N];
          a_sr  <= a_sr >> N;
          b_sr  <= b_sr >> N;
          if (last) begin
            idx       <= '0;
            cout      <= kc[N];
            ovf       <= kc[N] ^ kc[N-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer: a 4-chunk and a 1-chunk instance,
// expected results queued at accept and checked by per-DUT monitors.
module tb_wide_add_sequencer;
  import wide_add_pkg::*;

  localparam int N     = 16;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-chunk instance
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [W-1:0] a, b, sum;
  wadd_state_t  dbg_state;

  // 1-chunk instance
  logic         in_valid_s, in_ready_s, cin_s, sub_s, out_valid_s, out_ready_s, cout_s, ovf_s, busy_s;
  logic [N-1:0] a_s, b_s, sum_s;
  wadd_state_t  dbg_state_s;

  wide_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy),
    .dbg_state(dbg_state)
  );

  wide_add_sequencer #(.N(N), .WORDS(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .sum(sum_s), .cout(cout_s), .ovf(ovf_s), .busy(busy_s),
    .dbg_state(dbg_state_s)
  );

  // scoreboard
  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q[$];
  logic [N+1:0] exp_q_s[$];

  function automatic logic [W+1:0] mk(input logic c, input logic o, input logic [W-1:0] s);
    return {c, o, s};
  endfunction

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // monitors
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_result");
      else check("result", {cout, ovf, sum}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid_s && out_ready_s) begin
      if (exp_q_s.size() == 0) fail_now("unexpected_result_s");
      else check("result_s", {cout_s, ovf_s, sum_s}, exp_q_s.pop_front());
    end
  end

  // driver tasks: called at a negedge, return at the negedge after the accept edge
  task automatic drive(input bit sel, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic tsub, input bit push,
                       input logic [W+1:0] e, output int acc);
    int n;
    logic rdy;
    n = 0;
    if (!sel) begin
      a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    end else begin
      a_s = ta[N-1:0]; b_s = tb[N-1:0]; cin_s = tcin; sub_s = tsub; in_valid_s = 1'b1;
    end
    rdy = sel ? in_ready_s : in_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = sel ? in_ready_s : in_ready;
    end
    if (n >= 50) fail_now("accept_timeout");
    @(posedge clk);
    if (push) begin
      if (!sel) exp_q.push_back(e);
      else      exp_q_s.push_back({e[W+1:W], e[N-1:0]});
    end
    @(negedge clk);
    if (!sel) in_valid = 1'b0;
    else      in_valid_s = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_out(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? out_valid_s : out_valid) && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) fail_now("out_valid_timeout");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_q_s.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("drain_timeout");
  endtask

  initial begin
    int lat, acc0, acc1, acc2, hs;
    in_valid = 0; cin = 0; sub = 0; a = '0; b = '0; out_ready = 1;
    in_valid_s = 0; cin_s = 0; sub_s = 0; a_s = '0; b_s = '0; out_ready_s = 1;

    // reset values
    repeat (3) @(negedge clk);
    check("reset_out", {cout, ovf, sum}, '0);
    check("reset_ctl", {out_valid, busy, dbg_state}, {1'b0, 1'b0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {in_ready, busy, in_ready_s, busy_s}, 4'b1010);

    // all-ones plus one: full ripple through every chunk
    drive(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 1, mk(1, 0, 64'h0), acc0);
    wait_out(0, lat);
    check("t1_latency", lat, 4);

    // 5 - 7
    drive(0, 64'h5, 64'h7, 1, 1, 1, mk(0, 0, 64'hFFFF_FFFF_FFFF_FFFE), acc0);
    // positive overflow
    drive(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 1, mk(0, 1, 64'h8000_0000_0000_0000), acc0);
    // subtract with borrow across three chunks
    drive(0, 64'h0001_0000_0000_0000, 64'h1, 1, 1, 1, mk(1, 0, 64'h0000_FFFF_FFFF_FFFF), acc0);
    // negative overflow on subtract
    drive(0, 64'h8000_0000_0000_0000, 64'h1, 1, 1, 1, mk(1, 1, 64'h7FFF_FFFF_FFFF_FFFF), acc0);
    // cin alone carries into chunk 1
    drive(0, 64'h0000_0000_0000_FFFF, 64'h0, 1, 0, 1, mk(0, 0, 64'h0000_0000_0001_0000), acc0);
    wait_drain();

    // backpressure: result held while new operands wait
    out_ready = 1'b0;
    drive(0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 0, 0, 1,
          mk(0, 0, 64'h1234_5678_9ABC_DF00), acc0);
    wait_out(0, lat);
    a = 64'h0000_0000_FFFF_0000; b = 64'h0000_0000_0001_0000; cin = 0; sub = 0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_result", {cout, ovf, sum}, mk(0, 0, 64'h1234_5678_9ABC_DF00));
      check("hold_ctl", {in_ready, out_valid, dbg_state}, {1'b0, 1'b1, DONE});
    end
    out_ready = 1'b1;
    hs = cyc;
    drive(0, 64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 0, 0, 1,
          mk(0, 0, 64'h0000_0001_0000_0000), acc0);
    check("accept_after_handshake", acc0 - hs, 2);
    wait_drain();

    // reset while RUN at idx=2 aborts without a result
    drive(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 0, mk(0, 0, 64'h0), acc0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_ctl", {out_valid, busy}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_release", {in_ready, out_valid, busy}, 3'b100);
    check("abort_regs", {cout, ovf, sum}, '0);
    drive(0, 64'h1, 64'h1, 0, 0, 1, mk(0, 0, 64'h2), acc0);
    wait_drain();

    // single-chunk instance
    drive(1, 64'hFFFF, 64'h1, 0, 0, 1, mk(1, 0, 64'h0), acc0);
    wait_out(1, lat);
    check("s_latency", lat, 1);
    wait_drain();
    drive(1, 64'hFFFF, 64'h1, 0, 0, 1, mk(1, 0, 64'h0), acc0);
    drive(1, 64'h7FFF, 64'h1, 0, 0, 1, mk(0, 1, 64'h8000), acc1);
    drive(1, 64'h0005, 64'h7, 1, 1, 1, mk(0, 0, 64'hFFFE), acc2);
    check("s_spacing_1", acc1 - acc0, 3);
    check("s_spacing_2", acc2 - acc1, 3);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
